// File: rtl/net_pkg.sv
// Shared float constants, scheduler state encoding and helpers for net wrappers.
package net_pkg;

  localparam logic [31:0] FP_ONE  = 32'h3f80_0000;
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_HALF = 32'h3f00_0000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } sched_state_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // y > th for IEEE-754 single; negatives and NaNs never exceed a non-negative threshold.
  function automatic logic fp_gt_pos(input logic [31:0] y, input logic [31:0] th);
    if (y[31]) return 1'b0;
    if ((&y[30:23]) && (|y[22:0])) return 1'b0;
    return y[30:0] > th[30:0];
  endfunction

endpackage

// File: rtl/net_sched_if.sv
// Request and response channels between requesters/consumer and the net scheduler.
interface net_sched_if
  import net_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int I     = 2,
  parameter int W     = 32
);
  localparam int IDW = id_width(N_REQ);

  logic [N_REQ-1:0]     req_valid;
  logic [N_REQ-1:0]     req_ready;
  logic [N_REQ*I*W-1:0] req_x;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [W-1:0]         rsp_y;
  logic                 rsp_cls;
  logic                 rsp_err;

  modport master (
    output req_valid, req_x, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_y, rsp_cls, rsp_err
  );

  modport slave (
    input  req_valid, req_x, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_y, rsp_cls, rsp_err
  );
endinterface

// File: rtl/net_sched_rr_arbiter.sv
// Combinational round-robin pick: first requester searching upward from last+1.
module rr_arbiter
  import net_pkg::*;
#(
  parameter int N_REQ = 2,
  localparam int IDW  = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   last,
  output logic [N_REQ-1:0] grant,
  output logic [IDW-1:0]   idx,
  output logic             found
);

  always_comb begin
    int cand;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = (int'(last) + k) % N_REQ;
      if (!found && req[cand[IDW-1:0]]) begin
        found                  = 1'b1;
        grant[cand[IDW-1:0]]   = 1'b1;
        idx                    = cand[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/net_sched.sv
// Round-robin job scheduler sharing one net instance; NET_SCHED_TIMEOUT_EN adds a WAIT watchdog.
//   state    | meaning
//   ST_IDLE  | arbitrate, accept one request
//   ST_CLEAR | net held in reset one cycle (clears sticky done)
//   ST_START | net_start pulse
//   ST_WAIT  | wait for net_done (or watchdog terminal count)
//   ST_RESP  | response held until rsp_ready
module net_sched
  import net_pkg::*;
#(
  parameter int           N_REQ   = 2,
  parameter int           I       = 2,
  parameter int           W       = 32,
  parameter logic [W-1:0] THRESH  = 32'h3f00_0000,
  parameter int           TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst_n,
  net_sched_if.slave       bus,
  output logic             net_rst_n,
  output logic             net_start,
  output logic [I*W-1:0]   net_x,
  input  logic [W-1:0]     net_y,
  input  logic             net_done,
  output logic             busy,
  output logic [15:0]      jobs
);

  localparam int IDW = id_width(N_REQ);
  localparam int XW  = I * W;

  sched_state_t     state_q, state_d;
  logic             armed;
  logic [IDW-1:0]   last_q;
  logic [N_REQ-1:0] grant;
  logic [IDW-1:0]   grant_idx;
  logic             grant_found;
  logic             accept;
  logic             rsp_hs;
  logic             wd_tc;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req   (bus.req_valid),
    .last  (last_q),
    .grant (grant),
    .idx   (grant_idx),
    .found (grant_found)
  );

  // armed keeps every output at 0 until the first clock after reset release
  assign accept = armed && (state_q == ST_IDLE) && grant_found;
  assign rsp_hs = (state_q == ST_RESP) && bus.rsp_ready;

`ifdef NET_SCHED_TIMEOUT_EN
  localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  logic [WDW-1:0] wd_q;

  assign wd_tc = (wd_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q <= '0;
    end else if (state_q == ST_START) begin
      wd_q <= WDW'(TIMEOUT);
    end else if ((state_q == ST_WAIT) && !wd_tc) begin
      wd_q <= wd_q - WDW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_err <= 1'b0;
    end else if (state_q == ST_WAIT) begin
      if (net_done)   bus.rsp_err <= 1'b0;
      else if (wd_tc) bus.rsp_err <= 1'b1;
    end
  end
`else
  assign wd_tc       = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    bus.req_ready = '0;
    bus.rsp_valid = 1'b0;
    net_start     = 1'b0;
    net_rst_n     = armed;
    busy          = (state_q != ST_IDLE);
    unique case (state_q)
      ST_IDLE: begin
        if (armed) bus.req_ready = grant;
        if (accept) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        net_rst_n = 1'b0;
        state_d   = ST_START;
      end
      ST_START: begin
        net_start = 1'b1;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (net_done || wd_tc) state_d = ST_RESP;
      end
      ST_RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      armed       <= 1'b0;
      last_q      <= IDW'(N_REQ - 1);
      net_x       <= '0;
      bus.rsp_id  <= '0;
      bus.rsp_y   <= '0;
      bus.rsp_cls <= 1'b0;
      jobs        <= '0;
    end else begin
      state_q <= state_d;
      armed   <= 1'b1;
      if (accept) begin
        net_x      <= bus.req_x[int'(grant_idx)*XW +: XW];
        bus.rsp_id <= grant_idx;
        last_q     <= grant_idx;
      end
      if (state_q == ST_WAIT) begin
        if (net_done) begin
          bus.rsp_y   <= net_y;
          bus.rsp_cls <= fp_gt_pos(net_y, THRESH);
        end else if (wd_tc) begin
          bus.rsp_y   <= '0;
          bus.rsp_cls <= 1'b0;
        end
      end
      if (rsp_hs) jobs <= jobs + 16'd1;
    end
  end

endmodule

// File: tb/tb_net_sched.sv
// Directed bench for net_sched with a stub net (fixed latency, optional hang).
module tb_net_sched;
  import net_pkg::*;

  localparam int N_REQ = 2;
  localparam int I     = 2;
  localparam int W     = 32;
  localparam int TO    = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  net_sched_if #(.N_REQ(N_REQ), .I(I), .W(W)) bus ();

  logic           net_rst_n, net_start;
  logic           net_done = 1'b0;
  logic [I*W-1:0] net_x;
  logic [W-1:0]   net_y;
  logic           busy;
  logic [15:0]    jobs;

  net_sched #(.N_REQ(N_REQ), .I(I), .W(W), .THRESH(FP_HALF), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .net_rst_n (net_rst_n),
    .net_start (net_start),
    .net_x     (net_x),
    .net_y     (net_y),
    .net_done  (net_done),
    .busy      (busy),
    .jobs      (jobs)
  );

  // stub net: done rises stub_lat cycles after start unless hung; cleared by net reset
  logic        stub_hang = 1'b0;
  int          stub_lat  = 2;
  int          stub_cnt  = 0;
  logic [31:0] stub_y    = FP_ONE;
  assign net_y = stub_y;

  always @(posedge clk) begin
    if (!net_rst_n) begin
      net_done <= 1'b0;
      stub_cnt <= 0;
    end else if (net_start) begin
      stub_cnt <= stub_lat;
    end else if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1 && !stub_hang) net_done <= 1'b1;
    end
  end

  int n_pass   = 0;
  int n_tot    = 0;
  int exp_jobs = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      #1;
      if (bus.req_ready != '0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // offer a job from requester r; returns at the negedge of T+1 with req_valid dropped
  task automatic start_job(input string tag, input int r, input logic [63:0] x);
    bit ok;
    bus.req_x = '0;
    bus.req_x[r*I*W +: I*W] = x;
    bus.req_valid = '0;
    bus.req_valid[r] = 1'b1;
    wait_grant(ok);
    chk({tag, "_grant_seen"}, 64'(ok), 64'd1);
    chk({tag, "_grant"}, 64'(bus.req_ready), 64'd1 << r);
    @(negedge clk);
    bus.req_valid = '0;
    chk({tag, "_clear"}, 64'(net_rst_n), 64'd0);
    chk({tag, "_net_x"}, 64'(net_x), x);
  endtask

  task automatic run_job(input string tag, input int r, input logic [63:0] x,
                         input logic [31:0] y, input logic cls, input int lat, input int bp);
    int n;
    bit ok;
    stub_y    = y;
    stub_lat  = lat;
    stub_hang = 1'b0;
    bus.rsp_ready = (bp == 0);
    start_job(tag, r, x);
    @(negedge clk);
    chk({tag, "_start"}, 64'(net_start), 64'd1);
    n  = 2;
    ok = 1'b0;
    while (n < 100) begin
      if (bus.rsp_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      n++;
    end
    chk({tag, "_rsp_seen"}, 64'(ok), 64'd1);
    chk({tag, "_latency"}, 64'(n), 64'(4 + lat));
    chk({tag, "_id"}, 64'(bus.rsp_id), 64'(r));
    chk({tag, "_y"}, 64'(bus.rsp_y), 64'(y));
    chk({tag, "_cls"}, 64'(bus.rsp_cls), 64'(cls));
    chk({tag, "_err"}, 64'(bus.rsp_err), 64'd0);
    if (bp > 0) begin
      bus.req_valid = '0;
      bus.req_valid[(r + 1) % N_REQ] = 1'b1;
      repeat (bp) begin
        @(negedge clk);
        #1;
        chk({tag, "_hold_valid"}, 64'(bus.rsp_valid), 64'd1);
        chk({tag, "_hold_y"}, 64'(bus.rsp_y), 64'(y));
        chk({tag, "_hold_id"}, 64'(bus.rsp_id), 64'(r));
        chk({tag, "_hold_ready"}, 64'(bus.req_ready), 64'd0);
      end
      bus.req_valid = '0;
      bus.rsp_ready = 1'b1;
    end
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    exp_jobs++;
    chk({tag, "_rsp_drop"}, 64'(bus.rsp_valid), 64'd0);
    chk({tag, "_jobs"}, 64'(jobs), 64'(exp_jobs));
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  typedef struct {
    logic [31:0] y;
    logic        cls;
    int          r;
  } cls_vec_t;

  cls_vec_t tbl[8];

  initial begin
    int gi, ri, bad, n;
    bit ok;

    tbl[0] = '{32'h3f00_0000, 1'b0, 0};
    tbl[1] = '{32'h3f00_0001, 1'b1, 1};
    tbl[2] = '{32'hbf80_0000, 1'b0, 0};
    tbl[3] = '{32'h7fc0_0000, 1'b0, 1};
    tbl[4] = '{32'h3f80_0000, 1'b1, 0};
    tbl[5] = '{32'h7f80_0000, 1'b1, 1};
    tbl[6] = '{32'h0000_0000, 1'b0, 0};
    tbl[7] = '{32'h8000_0000, 1'b0, 1};

    bus.req_valid = 2'b11;
    bus.req_x     = '0;
    bus.rsp_ready = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_net_rst_n", 64'(net_rst_n), 64'd0);
    chk("rst_net_start", 64'(net_start), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_jobs", 64'(jobs), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_net_x", 64'(net_x), 64'd0);
    chk("rst_rsp_y", 64'(bus.rsp_y), 64'd0);

    // contention: both requesters valid out of reset
    @(negedge clk);
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    stub_lat = 2;
    gi = 0; ri = 0; bad = 0;
    for (int c = 0; c < 300 && ri < 4; c++) begin
      @(negedge clk);
      if (gi == 4) bus.req_valid = '0;
      #1;
      if ($countones(bus.req_ready) > 1) bad++;
      if (bus.req_ready != '0 && gi < 4) begin
        chk($sformatf("rr_grant%0d", gi), 64'(bus.req_ready), (gi % 2 == 0) ? 64'd1 : 64'd2);
        gi++;
      end
      if (bus.rsp_valid) begin
        chk($sformatf("rr_id%0d", ri), 64'(bus.rsp_id), 64'(ri % 2));
        ri++;
      end
    end
    chk("rr_responses", 64'(ri), 64'd4);
    chk("rr_onehot", 64'(bad), 64'd0);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    exp_jobs = 4;
    chk("rr_jobs", 64'(jobs), 64'd4);

    run_job("single", 0, {FP_ZERO, FP_ONE}, 32'h3f7d_70a4, 1'b1, 1, 0);
    run_job("bp", 1, {FP_ONE, FP_ZERO}, 32'h3f40_0000, 1'b1, 3, 10);
    repeat (3) @(negedge clk);
    chk("bp_single_rsp", 64'(bus.rsp_valid), 64'd0);

    for (int i = 0; i < 8; i++)
      run_job($sformatf("cls%0d", i), tbl[i].r, {FP_ONE, FP_ONE}, tbl[i].y, tbl[i].cls, 1 + (i % 3), 0);

    // hung net: watchdog response, or no response at all without the watchdog
    stub_hang = 1'b1;
    stub_lat  = 1;
    bus.rsp_ready = 1'b0;
`ifdef NET_SCHED_TIMEOUT_EN
    stub_y = FP_ONE;
    start_job("to", 0, {FP_ONE, FP_ONE});
    n = 1; ok = 1'b0;
    while (n < 200) begin
      if (bus.rsp_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      n++;
    end
    chk("to_rsp_seen", 64'(ok), 64'd1);
    chk("to_latency", 64'(n), 64'(4 + TO));
    chk("to_err", 64'(bus.rsp_err), 64'd1);
    chk("to_y", 64'(bus.rsp_y), 64'd0);
    chk("to_cls", 64'(bus.rsp_cls), 64'd0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    exp_jobs++;
    chk("to_jobs", 64'(jobs), 64'(exp_jobs));
    start_job("hang", 0, {FP_ONE, FP_ZERO});
    repeat (5) @(negedge clk);
`else
    start_job("hang", 0, {FP_ONE, FP_ZERO});
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (bus.rsp_valid) bad++;
    end
    chk("hang_no_rsp", 64'(bad), 64'd0);
    chk("hang_busy", 64'(busy), 64'd1);
`endif

    // reset in WAIT: immediate abort, then requester 0 first and jobs cleared
    bus.req_valid = 2'b11;
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_net_rst_n", 64'(net_rst_n), 64'd0);
    chk("mrst_net_x", 64'(net_x), 64'd0);
    chk("mrst_jobs", 64'(jobs), 64'd0);
    chk("mrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("mrst_req_ready", 64'(bus.req_ready), 64'd0);
    exp_jobs  = 0;
    stub_hang = 1'b0;
    stub_lat  = 1;
    stub_y    = 32'h3e80_0000;
    @(negedge clk);
    rst_n = 1'b1;
    wait_grant(ok);
    chk("mrst_grant_seen", 64'(ok), 64'd1);
    chk("mrst_grant", 64'(bus.req_ready), 64'd1);
    chk("mrst_jobs_after", 64'(jobs), 64'd0);
    @(negedge clk);
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("mrst_rsp_seen", 64'(ok), 64'd1);
    chk("mrst_rsp_id", 64'(bus.rsp_id), 64'd0);
    chk("mrst_rsp_cls", 64'(bus.rsp_cls), 64'd0);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("mrst_jobs_final", 64'(jobs), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
